// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IMEM_DEPTH x 32 instruction memory
// (asynchronous read, synchronous loader write) and the IF/ID pipeline register.
// Optional halt detection is enabled by defining IF_HALT_DETECT_EN. When it is
// enabled, a fetched 32'hFFFFFFFF parks the stage in HALTED until reset.
module instruction_fetch #(
  parameter int IMEM_DEPTH   = 256,
  parameter int NB_IMEM_ADDR = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic                    i_jump,
  input  logic [31:0]             i_jump_addr,
  input  logic                    i_imem_we,
  input  logic [NB_IMEM_ADDR-1:0] i_imem_waddr,
  input  logic [31:0]             i_imem_wdata,
  output logic [31:0]             o_pc,
  output logic [31:0]             o_pc4,
  output logic [31:0]             o_instruction,
  output logic                    o_halt
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_p0, state_nxt;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] pc4_p1, pc4_nxt;
  logic [31:0] instr_p1, instr_nxt;
  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;
  logic        is_halt_word;
  logic        jump_addr_unused;

  // Redirect targets are word aligned; the byte-offset bits are dropped.
  assign jump_addr_unused = ^i_jump_addr[1:0];

  // Asynchronous read: the word presented this cycle is the one stored
  // before any loader write landing on the same edge.
  assign fetch_word = imem[pc_p0[NB_IMEM_ADDR+1:2]];
  assign pc_plus4   = pc_p0 + 32'd4;

`ifdef IF_HALT_DETECT_EN
  assign is_halt_word = (fetch_word == 32'hFFFF_FFFF);
  assign o_halt       = (state_p0 == HALTED);
`else
  assign is_halt_word = 1'b0;
  assign o_halt       = 1'b0;
`endif

  // Loader write port, live in every state and independent of enable/stall.
  always_ff @(posedge i_clk) begin
    if (i_imem_we) imem[i_imem_waddr] <= i_imem_wdata;
  end

  // Next-state and next-PC/IF-ID selection; enable has priority over
  // halt, halt over jump, jump over stall, stall over flush.
  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    pc4_nxt   = pc4_p1;
    instr_nxt = instr_p1;
    if (!i_enable) begin
      // frozen
    end else if (state_p0 == HALTED) begin
      pc4_nxt   = 32'd0;
      instr_nxt = NOP;
    end else if (i_jump) begin
      pc_nxt    = {i_jump_addr[31:2], 2'b00};
      pc4_nxt   = 32'd0;
      instr_nxt = NOP;
    end else if (i_stall) begin
      // PC and IF/ID hold
    end else if (i_flush) begin
      pc_nxt    = pc_plus4;
      pc4_nxt   = 32'd0;
      instr_nxt = NOP;
    end else begin
      pc4_nxt   = pc_plus4;
      instr_nxt = fetch_word;
      if (is_halt_word) state_nxt = HALTED;
      else              pc_nxt    = pc_plus4;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_p0 <= RUN;
    else         state_p0 <= state_nxt;
  end

  // ---- stage boundary: PC (p0) and IF/ID register (p1) ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_p0    <= 32'd0;
      pc4_p1   <= 32'd0;
      instr_p1 <= NOP;
    end else begin
      pc_p0    <= pc_nxt;
      pc4_p1   <= pc4_nxt;
      instr_p1 <= instr_nxt;
    end
  end

  assign o_pc          = pc_p0;
  assign o_pc4         = pc4_p1;
  assign o_instruction = instr_p1;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Each step pushes the expected
// post-edge outputs to a scoreboard queue, clocks the DUT, then pops and
// compares. The halt section follows IF_HALT_DETECT_EN.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, enable, stall, flush, jump;
  logic [31:0] jump_addr;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pc, pc4, instruction;
  logic        halt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        halt;
  } exp_t;

  exp_t sb[$];

  instruction_fetch #(.IMEM_DEPTH(256), .NB_IMEM_ADDR(8)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_jump       (jump),
    .i_jump_addr  (jump_addr),
    .i_imem_we    (we),
    .i_imem_waddr (waddr),
    .i_imem_wdata (wdata),
    .o_pc         (pc),
    .o_pc4        (pc4),
    .o_instruction(instruction),
    .o_halt       (halt)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
  endtask

  task automatic step(input string tag, input logic r, input logic en,
                      input logic st, input logic fl, input logic jp,
                      input logic [31:0] ja, input logic [31:0] e_pc,
                      input logic [31:0] e_pc4, input logic [31:0] e_instr,
                      input logic e_halt);
    exp_t e;
    reset     = r;
    enable    = en;
    stall     = st;
    flush     = fl;
    jump      = jp;
    jump_addr = ja;
    sb.push_back('{tag, e_pc, e_pc4, e_instr, e_halt});
    @(posedge clk);
    #1;
    we = 1'b0;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty: got %0d entries, required >0", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (pc === e.pc) else begin
        errors++;
        $error("FAIL %s pc: got %h required %h", e.tag, pc, e.pc);
      end
      checks++;
      assert (pc4 === e.pc4) else begin
        errors++;
        $error("FAIL %s pc4: got %h required %h", e.tag, pc4, e.pc4);
      end
      checks++;
      assert (instruction === e.instr) else begin
        errors++;
        $error("FAIL %s instr: got %h required %h", e.tag, instruction, e.instr);
      end
      checks++;
      assert (halt === e.halt) else begin
        errors++;
        $error("FAIL %s halt: got %b required %b", e.tag, halt, e.halt);
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; stall = 1'b0; flush = 1'b0; jump = 1'b0;
    jump_addr = '0; we = 1'b0; waddr = '0; wdata = '0;
    #2;
    // reset wins over jump and stall
    step("rst0", 1, 1, 1, 0, 1, 32'h40, 0, 0, 0, 0);
    // loader writes while disabled: outputs frozen at reset values
    wr(8'd0,   32'h11);   step("ld0",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr(8'd1,   32'h22);   step("ld1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr(8'd2,   32'h33);   step("ld2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr(8'd3,   32'h44);   step("ld3",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr(8'd16,  32'h1600); step("ld16", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr(8'd255, 32'hFF00); step("ld255",0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // sequential fetch, stall, resume
    step("f0",   0, 1, 0, 0, 0, 0, 32'd4,  32'd4,  32'h11, 0);
    step("f1",   0, 1, 0, 0, 0, 0, 32'd8,  32'd8,  32'h22, 0);
    step("stl0", 0, 1, 1, 0, 0, 0, 32'd8,  32'd8,  32'h22, 0);
    step("stl1", 0, 1, 1, 0, 0, 0, 32'd8,  32'd8,  32'h22, 0);
    step("f2",   0, 1, 0, 0, 0, 0, 32'd12, 32'd12, 32'h33, 0);
    step("flush",0, 1, 0, 1, 0, 0, 32'd16, 32'd0,  32'h0,  0);
    // jump overrides stall/flush, target aligned
    step("jmp",  0, 1, 1, 1, 1, 32'h43, 32'h40, 32'd0, 32'h0, 0);
    step("jtgt", 0, 1, 0, 0, 0, 0, 32'h44, 32'h44, 32'h1600, 0);
    step("dis",  0, 0, 0, 0, 1, 32'h80, 32'h44, 32'h44, 32'h1600, 0);
    // memory index wrap
    step("jtop", 0, 1, 0, 0, 1, 32'h3FE, 32'h3FC, 32'd0, 32'h0, 0);
    step("ftop", 0, 1, 0, 0, 0, 0, 32'h400, 32'h400, 32'hFF00, 0);
    step("fwrap",0, 1, 0, 0, 0, 0, 32'h404, 32'h404, 32'h11, 0);
    // PC+4 wraps modulo 2^32
    step("jmax", 0, 1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'd0, 32'h0, 0);
    step("fmax", 0, 1, 0, 0, 0, 0, 32'd0, 32'd0, 32'hFF00, 0);
    // same-word write and fetch returns old contents
    wr(8'd0, 32'h99);
    step("rdw",  0, 1, 0, 0, 0, 0, 32'd4, 32'd4, 32'h11, 0);
    step("j0",   0, 1, 0, 0, 1, 32'h0, 32'd0, 32'd0, 32'h0, 0);
    step("rdnew",0, 1, 0, 0, 0, 0, 32'd4, 32'd4, 32'h99, 0);
    // write while disabled, then fetch it from reset
    step("rst2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr(8'd1, 32'hAB);
    step("dwr",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("g0",   0, 1, 0, 0, 0, 0, 32'd4, 32'd4, 32'h99, 0);
    step("g1",   0, 1, 0, 0, 0, 0, 32'd8, 32'd8, 32'hAB, 0);
    // halt word at word 3
    wr(8'd3, 32'hFFFF_FFFF);
    step("ldh",  0, 0, 0, 0, 0, 0, 32'd8, 32'd8, 32'hAB, 0);
    step("rst3", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("h0",   0, 1, 0, 0, 0, 0, 32'd4,  32'd4,  32'h99, 0);
    step("h1",   0, 1, 0, 0, 0, 0, 32'd8,  32'd8,  32'hAB, 0);
    step("h2",   0, 1, 0, 0, 0, 0, 32'd12, 32'd12, 32'h33, 0);
`ifdef IF_HALT_DETECT_EN
    step("hlat", 0, 1, 0, 0, 0, 0, 32'd12, 32'd16, 32'hFFFF_FFFF, 1);
    step("hnop", 0, 1, 0, 0, 0, 0, 32'd12, 32'd0,  32'h0, 1);
    step("hjmp", 0, 1, 0, 0, 1, 32'h40, 32'd12, 32'd0, 32'h0, 1);
    step("hdis", 0, 0, 0, 0, 0, 0, 32'd12, 32'd0,  32'h0, 1);
    step("hrst", 1, 1, 0, 0, 0, 0, 32'd0,  32'd0,  32'h0, 0);
    step("hrun", 0, 1, 0, 0, 0, 0, 32'd4,  32'd4,  32'h99, 0);
`else
    step("hord", 0, 1, 0, 0, 0, 0, 32'd16, 32'd16, 32'hFFFF_FFFF, 0);
    step("hjmp", 0, 1, 0, 0, 1, 32'h0, 32'd0, 32'd0, 32'h0, 0);
    step("hrun", 0, 1, 0, 0, 0, 0, 32'd4,  32'd4,  32'h99, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter IMEM_DEPTH, default 256, instruction memory depth in 32-bit words (power of two).
REQ-002 Parameter NB_IMEM_ADDR, default 8, word-address width, equal to log2(IMEM_DEPTH).
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 i_enable  input  1  run enable from the debug unit; 0 freezes the whole stage.
REQ-006 i_stall  input  1  hazard-unit stall; holds PC and IF/ID register.
REQ-007 i_flush  input  1  IF/ID register loads NOP; PC advances normally.
REQ-008 i_jump  input  1  redirect request from a taken jump or branch.
REQ-009 i_jump_addr  input  32  byte address of the redirect target.
REQ-010 i_imem_we  input  1  instruction-memory write strobe from the loader.
REQ-011 i_imem_waddr  input  NB_IMEM_ADDR  word address of the loader write.
REQ-012 i_imem_wdata  input  32  loader write data.
REQ-013 o_pc  output  32  current PC, byte address.
REQ-014 o_pc4  output  32  IF/ID register: PC+4 of the latched instruction.
REQ-015 o_instruction  output  32  IF/ID register: latched instruction word.
REQ-016 o_halt  output  1  high while the stage is in state HALTED.

Function
REQ-017 The instruction memory SHALL be an IMEM_DEPTH x 32 array with asynchronous read at index o_pc[NB_IMEM_ADDR+1:2] and synchronous write on i_imem_we.
REQ-018 PC indexing SHALL wrap modulo IMEM_DEPTH; PC+4 SHALL wrap modulo 2^32.
REQ-019 A fetch and a loader write to the same word in the same cycle SHALL return the pre-write contents.
REQ-020 Loader writes SHALL be accepted in every state, independent of i_enable, i_stall and halt.
REQ-021 Per-edge priority, highest first: i_reset, i_enable=0, i_jump, i_stall, i_flush, normal.
REQ-022 i_enable=0: PC, IF/ID register and FSM state SHALL hold.
REQ-023 i_jump=1: PC <= {i_jump_addr[31:2],2'b00}; IF/ID <= {pc4=0, instruction=NOP 32'h0}; i_stall and i_flush are ignored in that cycle.
REQ-024 i_stall=1 (no jump): PC and IF/ID register SHALL hold.
REQ-025 i_flush=1 (no jump, no stall): PC <= PC+4; IF/ID <= {0, NOP}.
REQ-026 Normal: PC <= PC+4; o_pc4 <= PC+4; o_instruction <= memory word at PC.
REQ-027 Latency: a word at PC SHALL appear on o_instruction one cycle after the edge that latches it; redirect target is fetched in the cycle after i_jump.
REQ-028 FSM states RUN and HALTED; HALTED is entered only per REQ-033.
REQ-029 In HALTED the PC SHALL hold, IF/ID SHALL load {0, NOP} each enabled cycle, and i_jump, i_stall, i_flush SHALL be ignored.
REQ-030 HALTED SHALL exit only via i_reset.

Reset
REQ-031 On i_reset=1 at an edge: o_pc=0, o_pc4=0, o_instruction=32'h0, o_halt=0, state RUN; reset overrides every other input, including mid-jump or mid-stall.
REQ-032 Instruction memory contents SHALL NOT be cleared by reset.

Configuration
REQ-033 Macro IF_HALT_DETECT_EN defined: in RUN, a normal fetch (REQ-026) of word 32'hFFFFFFFF latches it into IF/ID, holds PC at its address and enters HALTED the same edge; o_halt asserts the following cycle. Not defined: 32'hFFFFFFFF is fetched as an ordinary word, FSM stays RUN, o_halt is tied 0.

Verification
REQ-034 Load words 0x11,0x22,0x33 at 0..2, reset, enable 3 cycles -> o_instruction 0x11,0x22,0x33 with o_pc4 4,8,12.
REQ-035 i_stall=1 for 2 cycles after 0x22 latched -> o_instruction stays 0x22, o_pc stays 8; resumes 0x33.
REQ-036 i_jump=1, i_stall=1, i_jump_addr=0x43 same cycle -> o_pc=0x40, o_instruction=0 next cycle, word 16 appears the cycle after.
REQ-037 PC=4*(IMEM_DEPTH-1), normal fetch -> next fetch reads word 0 with o_pc=4*IMEM_DEPTH.
REQ-038 IF_HALT_DETECT_EN defined, 0xFFFFFFFF at word 3 -> o_halt=1 from cycle after its latch, o_pc holds 12, later i_jump ignored; i_reset -> o_halt=0, o_pc=0.
REQ-039 i_enable=0 with i_imem_we=1 to word 1 = 0xAB -> outputs frozen, then enable from reset fetches 0xAB at PC 4.
